// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the fetch-queue entry layout.
package cpu_types_pkg;

    localparam int CPU_WORD_W    = 32;
    localparam int FETCH_Q_DEPTH = 4;

    typedef logic [CPU_WORD_W-1:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t pc_plus_4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of fetch_queue signals; fq is the queue's view, tb the driver/monitor view.
interface fetch_queue_if #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 3
);
    logic              flush;
    logic              push_valid;
    logic              push_ready;
    logic [WORD_W-1:0] imemload;
    logic [WORD_W-1:0] pc_plus_4;
    logic              pop;
    logic              out_valid;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] out_pc_plus_4;
    logic [CNT_W-1:0]  count;

    modport fq (
        input  flush, push_valid, imemload, pc_plus_4, pop,
        output push_ready, out_valid, instr, out_pc_plus_4, count
    );

    modport tb (
        output flush, push_valid, imemload, pc_plus_4, pop,
        input  push_ready, out_valid, instr, out_pc_plus_4, count
    );
endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of {instr, pc_plus_4} between fetch and decode, flushable as a whole.
// Optional zero-latency empty-queue path when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue
    import cpu_types_pkg::*;
#(
    parameter  int WORD_W = 32,
    parameter  int DEPTH  = FETCH_Q_DEPTH,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [WORD_W-1:0] imemload,
    input  logic [WORD_W-1:0] pc_plus_4,
    input  logic              pop,
    output logic              out_valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] out_pc_plus_4,
    output logic [CNT_W-1:0]  count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WORD_W-1:0] instr_mem_q [DEPTH];
    logic [WORD_W-1:0] pc_mem_q    [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic head_valid;
    logic bypass_hit;
    logic consume_bypass;
    logic push_fire;
    logic pop_fire;
    logic wr_en;
    logic rd_en;

    always_comb begin
        head_valid = (count_q != '0);
        bypass_hit = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_hit = (count_q == '0) && push_valid && !flush;
`endif
        out_valid      = head_valid || bypass_hit;
        push_ready     = (count_q != FULL_CNT) || (pop && out_valid);
        push_fire      = push_valid && push_ready && !flush;
        pop_fire       = pop && out_valid && !flush;
        // A bypassed entry that decode takes immediately never touches storage.
        consume_bypass = bypass_hit && pop;
        wr_en          = push_fire && !consume_bypass;
        rd_en          = pop_fire && !consume_bypass;

        if (bypass_hit) begin
            instr         = imemload;
            out_pc_plus_4 = pc_plus_4;
        end else if (head_valid) begin
            instr         = instr_mem_q[rd_ptr_q];
            out_pc_plus_4 = pc_mem_q[rd_ptr_q];
        end else begin
            instr         = '0;
            out_pc_plus_4 = '0;
        end
        count = count_q;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; count gates whether its contents are visible.
    always_ff @(posedge CLK) begin
        if (nRST && !flush && wr_en) begin
            instr_mem_q[wr_ptr_q] <= imemload;
            pc_mem_q[wr_ptr_q]    <= pc_plus_4;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed table-driven bench for fetch_queue plus hand sequences for reset and bypass.
module tb_fetch_queue;

    localparam int WORD_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int NVEC   = 33;

    logic              clk;
    logic              nrst;
    logic              flush;
    logic              push_valid;
    logic              push_ready;
    logic [WORD_W-1:0] imemload;
    logic [WORD_W-1:0] pc_plus_4;
    logic              pop;
    logic              out_valid;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] out_pc_plus_4;
    logic [CNT_W-1:0]  count;

    int checks;
    int errors;

    typedef struct {
        logic              flush;
        logic              push_valid;
        logic              pop;
        logic [WORD_W-1:0] imemload;
        logic [WORD_W-1:0] pc;
        logic              exp_valid;
        logic [WORD_W-1:0] exp_instr;
        logic [WORD_W-1:0] exp_pc;
        logic [CNT_W-1:0]  exp_count;
        logic              exp_ready;
    } vec_t;

    vec_t vecs [NVEC];

    fetch_queue #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
        .CLK           (clk),
        .nRST          (nrst),
        .flush         (flush),
        .push_valid    (push_valid),
        .push_ready    (push_ready),
        .imemload      (imemload),
        .pc_plus_4     (pc_plus_4),
        .pop           (pop),
        .out_valid     (out_valid),
        .instr         (instr),
        .out_pc_plus_4 (out_pc_plus_4),
        .count         (count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic f, input logic pv, input logic p,
                         input logic [WORD_W-1:0] d, input logic [WORD_W-1:0] pc);
        flush      = f;
        push_valid = pv;
        pop        = p;
        imemload   = d;
        pc_plus_4  = pc;
    endtask

    function automatic vec_t mk(input logic f, input logic pv, input logic p,
                                input logic [WORD_W-1:0] d, input logic [WORD_W-1:0] pc,
                                input logic ev, input logic [WORD_W-1:0] ei,
                                input logic [WORD_W-1:0] ep, input int ec, input logic er);
        vec_t v;
        v.flush = f; v.push_valid = pv; v.pop = p; v.imemload = d; v.pc = pc;
        v.exp_valid = ev; v.exp_instr = ei; v.exp_pc = ep;
        v.exp_count = CNT_W'(ec); v.exp_ready = er;
        return v;
    endfunction

    initial begin
        vec_t v;
        string tag;
        checks = 0;
        errors = 0;
        nrst   = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);

        //           fl pv pop imemload      pc        | valid instr         pc     cnt rdy
        vecs[0]  = mk(0, 0, 0, 32'h0,        32'h0,      0, 32'h0,        32'h0,   0, 1);
        vecs[1]  = mk(0, 1, 0, 32'h8C010004, 32'h4,      0, 32'h0,        32'h0,   0, 1);
        vecs[2]  = mk(0, 0, 0, 32'h0,        32'h0,      1, 32'h8C010004, 32'h4,   1, 1);
        vecs[3]  = mk(0, 0, 1, 32'h0,        32'h0,      1, 32'h8C010004, 32'h4,   1, 1);
        vecs[4]  = mk(0, 0, 0, 32'h0,        32'h0,      0, 32'h0,        32'h0,   0, 1);
        vecs[5]  = mk(0, 1, 0, 32'hA0000000, 32'h100,    0, 32'h0,        32'h0,   0, 1);
        vecs[6]  = mk(0, 1, 0, 32'hA0000001, 32'h104,    1, 32'hA0000000, 32'h100, 1, 1);
        vecs[7]  = mk(0, 1, 0, 32'hA0000002, 32'h108,    1, 32'hA0000000, 32'h100, 2, 1);
        vecs[8]  = mk(0, 1, 0, 32'hA0000003, 32'h10C,    1, 32'hA0000000, 32'h100, 3, 1);
        vecs[9]  = mk(0, 1, 0, 32'hDEADBEEF, 32'hBAD,    1, 32'hA0000000, 32'h100, 4, 0);
        vecs[10] = mk(0, 0, 0, 32'h0,        32'h0,      1, 32'hA0000000, 32'h100, 4, 0);
        vecs[11] = mk(0, 1, 1, 32'hB0000000, 32'h200,    1, 32'hA0000000, 32'h100, 4, 1);
        vecs[12] = mk(0, 0, 0, 32'h0,        32'h0,      1, 32'hA0000001, 32'h104, 4, 0);
        vecs[13] = mk(0, 0, 1, 32'h0,        32'h0,      1, 32'hA0000001, 32'h104, 4, 1);
        vecs[14] = mk(0, 0, 1, 32'h0,        32'h0,      1, 32'hA0000002, 32'h108, 3, 1);
        vecs[15] = mk(0, 0, 1, 32'h0,        32'h0,      1, 32'hA0000003, 32'h10C, 2, 1);
        vecs[16] = mk(0, 0, 1, 32'h0,        32'h0,      1, 32'hB0000000, 32'h200, 1, 1);
        vecs[17] = mk(0, 0, 0, 32'h0,        32'h0,      0, 32'h0,        32'h0,   0, 1);
        vecs[18] = mk(0, 0, 1, 32'h0,        32'h0,      0, 32'h0,        32'h0,   0, 1);
        vecs[19] = mk(0, 0, 1, 32'h0,        32'h0,      0, 32'h0,        32'h0,   0, 1);
        vecs[20] = mk(0, 0, 1, 32'h0,        32'h0,      0, 32'h0,        32'h0,   0, 1);
        vecs[21] = mk(0, 1, 0, 32'hC0000000, 32'h300,    0, 32'h0,        32'h0,   0, 1);
        vecs[22] = mk(0, 0, 0, 32'h0,        32'h0,      1, 32'hC0000000, 32'h300, 1, 1);
        vecs[23] = mk(0, 1, 0, 32'hC0000001, 32'h304,    1, 32'hC0000000, 32'h300, 1, 1);
        vecs[24] = mk(0, 1, 0, 32'hC0000002, 32'h308,    1, 32'hC0000000, 32'h300, 2, 1);
        vecs[25] = mk(1, 1, 1, 32'hD0000000, 32'h500,    1, 32'hC0000000, 32'h300, 3, 1);
        vecs[26] = mk(0, 0, 0, 32'h0,        32'h0,      0, 32'h0,        32'h0,   0, 1);
        vecs[27] = mk(0, 1, 0, 32'hE0000000, 32'h400,    0, 32'h0,        32'h0,   0, 1);
        vecs[28] = mk(0, 0, 0, 32'h0,        32'h0,      1, 32'hE0000000, 32'h400, 1, 1);
        vecs[29] = mk(0, 1, 1, 32'hE0000001, 32'h404,    1, 32'hE0000000, 32'h400, 1, 1);
        vecs[30] = mk(0, 0, 0, 32'h0,        32'h0,      1, 32'hE0000001, 32'h404, 1, 1);
        vecs[31] = mk(0, 0, 1, 32'h0,        32'h0,      1, 32'hE0000001, 32'h404, 1, 1);
        vecs[32] = mk(0, 0, 0, 32'h0,        32'h0,      0, 32'h0,        32'h0,   0, 1);

`ifdef FETCH_QUEUE_BYPASS_EN
        // An empty queue with a push in flight shows the incoming word directly.
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].exp_count == '0 && vecs[i].push_valid && !vecs[i].flush) begin
                vecs[i].exp_valid = 1'b1;
                vecs[i].exp_instr = vecs[i].imemload;
                vecs[i].exp_pc    = vecs[i].pc;
            end
        end
`endif

        repeat (2) @(negedge clk);
        nrst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            v = vecs[i];
            drive(v.flush, v.push_valid, v.pop, v.imemload, v.pc);
            #1;
            tag = $sformatf("v%0d", i);
            check({tag, ".out_valid"},  WORD_W'(out_valid),  WORD_W'(v.exp_valid));
            check({tag, ".instr"},      instr,               v.exp_instr);
            check({tag, ".pc_plus_4"},  out_pc_plus_4,       v.exp_pc);
            check({tag, ".count"},      WORD_W'(count),      WORD_W'(v.exp_count));
            check({tag, ".push_ready"}, WORD_W'(push_ready), WORD_W'(v.exp_ready));
        end

        // Reset mid-stream drops everything, even with a push on the reset edge.
        @(negedge clk); drive(0, 1, 0, 32'hF0000000, 32'h600);
        @(negedge clk); drive(0, 1, 0, 32'hF0000001, 32'h604);
        @(negedge clk); nrst = 1'b0; drive(0, 1, 0, 32'hF0000002, 32'h608);
        @(negedge clk); nrst = 1'b1; drive(0, 0, 0, '0, '0);
        #1;
        check("rst.count",      WORD_W'(count),      32'd0);
        check("rst.out_valid",  WORD_W'(out_valid),  32'd0);
        check("rst.instr",      instr,               32'h0);
        check("rst.push_ready", WORD_W'(push_ready), 32'd1);
        @(negedge clk); drive(0, 1, 0, 32'h12345678, 32'h700);
        @(negedge clk); drive(0, 0, 0, '0, '0);
        #1;
        check("rst.next_head",  instr,               32'h12345678);
        check("rst.next_pc",    out_pc_plus_4,       32'h700);
        check("rst.next_count", WORD_W'(count),      32'd1);
        @(negedge clk); drive(0, 0, 1, '0, '0);
        @(negedge clk); drive(0, 0, 0, '0, '0);
        #1;
        check("rst.drain", WORD_W'(count), 32'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
        // Empty queue, push with pop: consumed in the same cycle, never stored.
        @(negedge clk); drive(0, 1, 1, 32'h20020001, 32'h8);
        #1;
        check("byp.out_valid", WORD_W'(out_valid), 32'd1);
        check("byp.instr",     instr,              32'h20020001);
        check("byp.pc",        out_pc_plus_4,      32'h8);
        @(negedge clk); drive(0, 0, 0, '0, '0);
        #1;
        check("byp.count",     WORD_W'(count),     32'd0);
        check("byp.after",     WORD_W'(out_valid), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
